gate_truth_checker: RTL
=======================

# gate_truth_checker

Hardware self-checking sweeper for the two-input gate cells (`and_gate`, `nand_gate`, `xnor_gate`). It drives the four A/B input combinations into the gates under test and samples their Y outputs after a programmable settle time. Each sample is compared against the expected truth table, and the block reports pass/fail, a mismatch count and per-gate failure flags. It sits on the stimulus/response side of the gate cells and replaces the simulation-only bench sweep in on-chip or emulation builds.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: clock cycles between driving a vector and the check cycle. Legal range 0..255.

Ports:
- `clk`  in  1: clock, rising-edge active.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a sweep. Sampled in IDLE or DONE only.
- `a_out`  out  1: A stimulus to the gates.
- `b_out`  out  1: B stimulus to the gates.
- `y_and`  in  1: AND gate output.
- `y_nand`  in  1: NAND gate output.
- `y_xnor`  in  1: XNOR gate output.
- `busy`  out  1: high while a sweep is running.
- `done`  out  1: level, high in DONE until the next start or reset.
- `pass`  out  1: valid when `done`=1; high iff `err_count`==0.
- `err_count`  out  3: number of vectors (0..4) with at least one gate mismatch.
- `fail_mask`  out  3: sticky per-gate fail flags. bit0 AND, bit1 NAND, bit2 XNOR.

## Operation
- Vector index `idx` runs 0..3 with `a_out`=`idx[1]` and `b_out`=`idx[0]`. Order is 00, 01, 10, 11.
- Expected values:
  - AND = a&b
  - NAND = ~(a&b)
  - XNOR = ~(a^b)
  - Any non-0/1 input value counts as a mismatch.
- FSM states are IDLE, SETTLE, CHECK and DONE.
- IDLE/DONE, with `start`=1:
  - `idx`←0 and `a_out`/`b_out`←00.
  - `err_count`, `fail_mask` and `pass` are cleared; `done`←0.
  - Next state is SETTLE, or CHECK if `SETTLE_CYCLES`=0.
- SETTLE: stays for exactly `SETTLE_CYCLES` cycles via a down-counter, then goes to CHECK.
- CHECK (exactly one cycle): compares `y_*` against the expected values.
  - Any mismatch: `err_count` increments and the failing bits are ORed into `fail_mask`.
  - If `idx`<3: `idx` increments, the new vector is driven at the same edge, and the FSM goes to SETTLE (or stays in CHECK if `SETTLE_CYCLES`=0).
  - If `idx`=3: goes to DONE with `pass`←(final `err_count`==0).
- DONE: outputs hold until the next `start`. `a_out`/`b_out` hold at 11.
- `start` while `busy` is ignored.
- Reset, including mid-sweep, returns to IDLE:
  - `a_out`=`b_out`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_mask`=0, all optional outputs 0.

## Timing
- `busy` is a registered output, high in SETTLE and CHECK.
- Each vector takes `SETTLE_CYCLES`+1 cycles.
- `done` rises 4×(`SETTLE_CYCLES`+1) cycles after the edge that sampled `start`.
- `y_*` are sampled at the rising edge that ends the CHECK cycle. Inputs must be stable `SETTLE_CYCLES` cycles after the drive edge.
- The stimulus changes only at the edge leaving CHECK (or the start edge). It never changes during SETTLE.
- Counters and flags update at the CHECK-exit edge. `pass` is registered at the same edge `done` rises.

## Configuration
- `GATE_CHK_FIRST_FAIL_EN` defined: adds outputs `first_fail_valid` (1), `first_fail_idx` (2) and `first_fail_y` (3, {xnor, nand, and} as observed).
  - Captured at the first mismatching CHECK of a sweep and frozen until the next `start`/`rst`.
  - All three are cleared to 0 by `start` and `rst`.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Correct gates, `SETTLE_CYCLES`=1, `start` pulse:
  - `a_out`/`b_out` sequence is 00, 01, 10, 11, each held 2 cycles.
  - `done` rises 8 cycles after start with `pass`=1, `err_count`=0, `fail_mask`=000.
- `y_nand` tied to 0:
  - Mismatches on 3 vectors (idx 0, 1, 2; NAND expected 1 there, 0 only at 11).
  - `err_count`=3, `fail_mask`=010, `pass`=0.
  - With macro: `first_fail_idx`=0, `first_fail_y`={1,0,0}.
- `y_xnor` inverted, `y_and` stuck at 1:
  - Every vector mismatches: `err_count`=4, `fail_mask`=101.
- `SETTLE_CYCLES`=0:
  - Sweep completes with `done` 4 cycles after start.
  - `start` pulsed during `busy` has no effect.
  - A second `start` in DONE clears the results and reruns the sweep.
- `rst` asserted mid-SETTLE of vector 2:
  - Outputs go to reset values asynchronously and the FSM returns to IDLE.
  - After reset, `start` runs a full clean sweep with `pass`=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Sweeps the four A/B vectors into the and/nand/xnor cells and checks each Y against its truth table.
// Optional first-failure capture is enabled by defining GATE_CHK_FIRST_FAIL_EN.
module gate_truth_checker #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_out,
   output logic       b_out,
   input  logic       y_and,
   input  logic       y_nand,
   input  logic       y_xnor,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [2:0] fail_mask
`ifdef GATE_CHK_FIRST_FAIL_EN
   ,
   output logic       first_fail_valid,
   output logic [1:0] first_fail_idx,
   output logic [2:0] first_fail_y
`endif
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
   localparam logic ZERO_SETTLE = (SETTLE_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [2:0]       err_q, err_d;
   logic [2:0]       mask_q, mask_d;
   logic             ffv_q, ffv_d;
   logic [1:0]       ffi_q, ffi_d;
   logic [2:0]       ffy_q, ffy_d;

   logic [2:0] exp_y;
   logic [2:0] obs_y;
   logic [2:0] mism;
   logic       mism_any;

   // Expected {xnor, nand, and} for the vector currently driven; X/Z on a Y counts as a mismatch.
   always_comb begin
      exp_y    = {~(idx_q[1] ^ idx_q[0]), ~(idx_q[1] & idx_q[0]), idx_q[1] & idx_q[0]};
      obs_y    = {y_xnor, y_nand, y_and};
      mism[0]  = (y_and  !== exp_y[0]);
      mism[1]  = (y_nand !== exp_y[1]);
      mism[2]  = (y_xnor !== exp_y[2]);
      mism_any = |mism;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
         ffv_q   <= 1'b0;
         ffi_q   <= '0;
         ffy_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         ffv_q   <= ffv_d;
         ffi_q   <= ffi_d;
         ffy_q   <= ffy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = ZERO_SETTLE ? CHECK : SETTLE;
         SETTLE:     if (cnt_q == '0) state_d = CHECK;
         CHECK: begin
            if (idx_q == 2'd3) state_d = DONE;
            else               state_d = ZERO_SETTLE ? CHECK : SETTLE;
         end
         default:    state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      busy_d = busy_q;
      done_d = done_q;
      pass_d = pass_q;
      err_d  = err_q;
      mask_d = mask_q;
      ffv_d  = ffv_q;
      ffi_d  = ffi_q;
      ffy_d  = ffy_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               idx_d  = '0;
               cnt_d  = SETTLE_LOAD;
               busy_d = 1'b1;
               done_d = 1'b0;
               pass_d = 1'b0;
               err_d  = '0;
               mask_d = '0;
               ffv_d  = 1'b0;
               ffi_d  = '0;
               ffy_d  = '0;
            end
         end
         SETTLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         end
         CHECK: begin
            if (mism_any) begin
               err_d  = err_q + 3'd1;
               mask_d = mask_q | mism;
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
                  ffy_d = obs_y;
               end
            end
            if (idx_q == 2'd3) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               pass_d = (err_d == 3'd0);
            end else begin
               idx_d = idx_q + 2'd1;
               cnt_d = SETTLE_LOAD;
            end
         end
         default: ;
      endcase
   end

   assign a_out     = idx_q[1];
   assign b_out     = idx_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
   assign first_fail_valid = ffv_q;
   assign first_fail_idx   = ffi_q;
   assign first_fail_y     = ffy_q;
`else
   logic unused_ff;
   assign unused_ff = ^{ffv_q, ffi_q, ffy_q};
`endif

endmodule
